// File: rtl/vga_frame_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_frame_gen_if
// Description : Pixel-coordinate / widget-return / VGA-pin bundle for
//               vga_frame_gen.
//               master : frame generator (drives X/Y, RGB, syncs, frameTick;
//                        samples widget hits/colours and the background)
//               slave  : widget side and connector (mirror directions)
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_frame_gen_if;
  logic [10:0] X;
  logic [10:0] Y;
  logic        yes0;
  logic [3:0]  red0, green0, blue0;
  logic        yes1;
  logic [3:0]  red1, green1, blue1;
  logic [3:0]  bgRed, bgGreen, bgBlue;
  logic [3:0]  red, green, blue;
  logic        hsync, vsync, frameTick;

  modport master (
    output X, Y, red, green, blue, hsync, vsync, frameTick,
    input  yes0, red0, green0, blue0, yes1, red1, green1, blue1,
    input  bgRed, bgGreen, bgBlue
  );

  modport slave (
    input  X, Y, red, green, blue, hsync, vsync, frameTick,
    output yes0, red0, green0, blue0, yes1, red1, green1, blue1,
    output bgRed, bgGreen, bgBlue
  );
endinterface
`default_nettype wire

// File: rtl/vga_frame_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_frame_gen
// Description : 800x600@72 Hz VGA timing generator. Runs the X/Y pixel
//               counters, resolves widget priority against the background,
//               and registers RGB, hsync/vsync (active-high) and a
//               once-per-frame frameTick at the start of vertical blanking.
//               Optional build macro VGA_BORDER_EN: paints a white 1-pixel
//               border around the active area.
// Ports       : clk   - pixel clock, rising edge
//               reset - asynchronous, active-low
//               bus   - vga_frame_gen_if.master (X/Y out, widget hits and
//                       colours in, background in, RGB/syncs/frameTick out)
// Revision    : 1.0 - initial release
// ============================================================================
module vga_frame_gen #(
  parameter int H_VISIBLE = 800,
  parameter int H_FRONT   = 56,
  parameter int H_SYNC    = 120,
  parameter int H_BACK    = 64,
  parameter int V_VISIBLE = 600,
  parameter int V_FRONT   = 37,
  parameter int V_SYNC    = 6,
  parameter int V_BACK    = 23
) (
  input  logic            clk,
  input  logic            reset,
  vga_frame_gen_if.master bus
);

  localparam logic [10:0] c_h_last     = 11'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [10:0] c_v_last     = 11'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [10:0] c_h_vis      = 11'(H_VISIBLE);
  localparam logic [10:0] c_v_vis      = 11'(V_VISIBLE);
  localparam logic [10:0] c_hs_first   = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] c_hs_last    = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [10:0] c_vs_first   = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] c_vs_last    = 11'(V_VISIBLE + V_FRONT + V_SYNC - 1);
`ifdef VGA_BORDER_EN
  localparam logic [10:0] c_h_vis_last = 11'(H_VISIBLE - 1);
  localparam logic [10:0] c_v_vis_last = 11'(V_VISIBLE - 1);
`endif

  logic [10:0] r_x, r_y;
  logic [11:0] r_rgb;
  logic        r_hsync, r_vsync, r_tick;

  logic        w_active;
  logic [11:0] w_rgb;

  // Pixel/line counters; the line counter only moves on the last column.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x <= '0;
      r_y <= '0;
    end else if (r_x == c_h_last) begin
      r_x <= '0;
      r_y <= (r_y == c_v_last) ? 11'd0 : r_y + 11'd1;
    end else begin
      r_x <= r_x + 11'd1;
    end
  end

  assign w_active = (r_x < c_h_vis) && (r_y < c_v_vis);

  // Colour priority: blanking black, then widget 0, widget 1, background.
  always_comb begin
    w_rgb = 12'h000;
    if (w_active) begin
      if (bus.yes0)
        w_rgb = {bus.red0, bus.green0, bus.blue0};
      else if (bus.yes1)
        w_rgb = {bus.red1, bus.green1, bus.blue1};
      else
        w_rgb = {bus.bgRed, bus.bgGreen, bus.bgBlue};
`ifdef VGA_BORDER_EN
      if ((r_x == 11'd0) || (r_x == c_h_vis_last) ||
          (r_y == 11'd0) || (r_y == c_v_vis_last))
        w_rgb = 12'hFFF;
`endif
    end
  end

  // Colour and sync decodes share one register stage so they stay aligned
  // with each other, one clock behind the X/Y that produced them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rgb   <= 12'h000;
      r_hsync <= 1'b0;
      r_vsync <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_rgb   <= w_rgb;
      r_hsync <= (r_x >= c_hs_first) && (r_x <= c_hs_last);
      r_vsync <= (r_y >= c_vs_first) && (r_y <= c_vs_last);
      r_tick  <= (r_x == 11'd0) && (r_y == c_v_vis);
    end
  end

  assign bus.X         = r_x;
  assign bus.Y         = r_y;
  assign bus.red       = r_rgb[11:8];
  assign bus.green     = r_rgb[7:4];
  assign bus.blue      = r_rgb[3:0];
  assign bus.hsync     = r_hsync;
  assign bus.vsync     = r_vsync;
  assign bus.frameTick = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_frame_gen
// Description : Self-checking bench for vga_frame_gen. A shrunken-timing
//               instance covers whole frames, a default-timing instance
//               covers the first lines; both follow a position model derived
//               from the number of clocks since reset release.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_frame_gen;

  logic clk = 1'b0;
  logic reset;
  always #10 clk = ~clk;

  vga_frame_gen_if ifs ();
  vga_frame_gen_if ifd ();

  // Small timing: line 64 (vis 40, hsync 46..53), frame 40 lines (vis 30,
  // vsync 33..34), frame period 2560 clocks.
  vga_frame_gen #(
    .H_VISIBLE(40), .H_FRONT(6), .H_SYNC(8), .H_BACK(10),
    .V_VISIBLE(30), .V_FRONT(3), .V_SYNC(2), .V_BACK(5)
  ) dut_s (.clk(clk), .reset(reset), .bus(ifs));

  vga_frame_gen dut_d (.clk(clk), .reset(reset), .bus(ifd));

  logic        s_yes0, s_yes1;
  logic [11:0] s_c0, s_c1, s_bg;

  assign ifs.yes0 = s_yes0; assign ifs.yes1 = s_yes1;
  assign ifs.red0 = s_c0[11:8]; assign ifs.green0 = s_c0[7:4]; assign ifs.blue0 = s_c0[3:0];
  assign ifs.red1 = s_c1[11:8]; assign ifs.green1 = s_c1[7:4]; assign ifs.blue1 = s_c1[3:0];
  assign ifs.bgRed = s_bg[11:8]; assign ifs.bgGreen = s_bg[7:4]; assign ifs.bgBlue = s_bg[3:0];
  assign ifd.yes0 = s_yes0; assign ifd.yes1 = s_yes1;
  assign ifd.red0 = s_c0[11:8]; assign ifd.green0 = s_c0[7:4]; assign ifd.blue0 = s_c0[3:0];
  assign ifd.red1 = s_c1[11:8]; assign ifd.green1 = s_c1[7:4]; assign ifd.blue1 = s_c1[3:0];
  assign ifd.bgRed = s_bg[11:8]; assign ifd.bgGreen = s_bg[7:4]; assign ifd.bgBlue = s_bg[3:0];

  int   errors = 0;
  int   checks = 0;
  int   n;              // rising edges since reset release
  int   last_tick_n;
  int   ticks_s;
  int   first_hs_rise;
  logic prev_hs_d;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected {rgb, hsync, vsync, frameTick} for a pixel at (px,py).
  function automatic logic [14:0] ref_out(input int px, input int py, input int hv, input int vv,
                                          input int hs0, input int hs1, input int vs0, input int vs1,
                                          input logic y0, input logic y1,
                                          input logic [11:0] c0, input logic [11:0] c1,
                                          input logic [11:0] bg);
    logic [11:0] rgb;
    rgb = 12'h000;
    if (px < hv && py < vv) begin
      if (y0)      rgb = c0;
      else if (y1) rgb = c1;
      else         rgb = bg;
`ifdef VGA_BORDER_EN
      if (px == 0 || px == hv - 1 || py == 0 || py == vv - 1) rgb = 12'hFFF;
`endif
    end
    return {rgb, (px >= hs0 && px <= hs1), (py >= vs0 && py <= vs1), (px == 0 && py == vv)};
  endfunction

  function automatic logic [31:0] outs_s();
    return 32'({ifs.red, ifs.green, ifs.blue, ifs.hsync, ifs.vsync, ifs.frameTick});
  endfunction

  function automatic logic [31:0] outs_d();
    return 32'({ifd.red, ifd.green, ifd.blue, ifd.hsync, ifd.vsync, ifd.frameTick});
  endfunction

  function automatic logic [31:0] rgb_s();
    return 32'({ifs.red, ifs.green, ifs.blue});
  endfunction

  task automatic rand_inputs();
    s_yes0 = 1'($urandom_range(0, 1));
    s_yes1 = 1'($urandom_range(0, 1));
    s_c0   = 12'($urandom);
    s_c1   = 12'($urandom);
    s_bg   = 12'($urandom);
  endtask

  // One clock: predict from the current model position and inputs, then
  // compare both instances after the edge.
  task automatic step();
    logic [14:0] es, ed;
    es = ref_out(n % 64, (n / 64) % 40, 40, 30, 46, 53, 33, 34, s_yes0, s_yes1, s_c0, s_c1, s_bg);
    ed = ref_out(n % 1040, (n / 1040) % 666, 800, 600, 856, 975, 637, 642,
                 s_yes0, s_yes1, s_c0, s_c1, s_bg);
    @(posedge clk); #1;
    n++;
    check("s_X", 32'(ifs.X), 32'(n % 64));
    check("s_Y", 32'(ifs.Y), 32'((n / 64) % 40));
    check("s_outputs", outs_s(), 32'(es));
    check("d_X", 32'(ifd.X), 32'(n % 1040));
    check("d_Y", 32'(ifd.Y), 32'((n / 1040) % 666));
    check("d_outputs", outs_d(), 32'(ed));
    if (ifs.frameTick === 1'b1) begin
      if (last_tick_n >= 0) check("tick_period", 32'(n - last_tick_n), 32'd2560);
      last_tick_n = n;
      ticks_s++;
    end
    if (ifd.hsync === 1'b1 && prev_hs_d === 1'b0 && first_hs_rise < 0) first_hs_rise = n;
    prev_hs_d = ifd.hsync;
  endtask

  // Random clocks until the small instance sits at (tx,ty), bounded.
  task automatic goto_s(input int tx, input int ty);
    int guard;
    guard = 0;
    while (!((n % 64) == tx && ((n / 64) % 40) == ty) && guard < 3000) begin
      rand_inputs();
      step();
      guard++;
    end
    if (guard >= 3000) check("goto_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_s_X"},  32'(ifs.X), 32'd0);
    check({tag, "_s_Y"},  32'(ifs.Y), 32'd0);
    check({tag, "_s_out"}, outs_s(), 32'd0);
    check({tag, "_d_X"},  32'(ifd.X), 32'd0);
    check({tag, "_d_Y"},  32'(ifd.Y), 32'd0);
    check({tag, "_d_out"}, outs_d(), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    s_yes0 = 1'b0; s_yes1 = 1'b0; s_c0 = '0; s_c1 = '0; s_bg = '0;
    n = 0; last_tick_n = -1; ticks_s = 0; first_hs_rise = -1; prev_hs_d = 1'b0;

    // Reset held for 5 clocks.
    repeat (5) begin
      @(posedge clk); #1;
      check_reset_state("reset_hold");
    end
    reset = 1'b1;

    // Priority at an active pixel.
    goto_s(10, 10);
    s_yes0 = 1'b1; s_yes1 = 1'b1; s_c0 = 12'hF00; s_c1 = 12'h0F0; s_bg = 12'h123;
    step(); check("prio_both_hit", rgb_s(), 32'h0F00);
    s_yes0 = 1'b0;
    step(); check("prio_w1_only", rgb_s(), 32'h00F0);
    s_yes1 = 1'b0;
    step(); check("prio_bg", rgb_s(), 32'h0123);

    // Blanking: horizontal and vertical.
    goto_s(50, 10);
    s_yes0 = 1'b1; s_c0 = 12'hF00; s_bg = 12'h123;
    step(); check("hblank_black", rgb_s(), 32'h0000);
    goto_s(5, 35);
    s_yes0 = 1'b1; s_c0 = 12'hF00; s_bg = 12'h123;
    step(); check("vblank_black", rgb_s(), 32'h0000);

    // Left-edge pixel.
    goto_s(0, 5);
    s_yes0 = 1'b1; s_yes1 = 1'b0; s_c0 = 12'hF00; s_bg = 12'h123;
    step();
`ifdef VGA_BORDER_EN
    check("edge_pixel", rgb_s(), 32'h0FFF);
`else
    check("edge_pixel", rgb_s(), 32'h0F00);
`endif

    // Two small frames; default instance covers five lines.
    while (n < 5400) begin
      rand_inputs();
      step();
    end
    check("hsync_first_rise", 32'(first_hs_rise), 32'd857);
    check("tick_count_2frames", 32'(ticks_s), 32'd2);

    // Mid-frame asynchronous reset.
    goto_s(20, 15);
    #4 reset = 1'b0;
    #1 check_reset_state("reset_async");
    repeat (5) begin
      @(posedge clk); #1;
      check_reset_state("reset_mid");
    end
    reset = 1'b1;
    n = 0; last_tick_n = -1; ticks_s = 0;
    while (n < 2600) begin
      rand_inputs();
      step();
    end
    check("tick_count_after_reset", 32'(ticks_s), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_frame_gen.md
# vga_frame_gen

Generates 800x600@72 Hz VGA timing from a 50 MHz pixel clock and drives the pixel-coordinate bus (`X`, `Y`) that sprite widgets consume. It takes back each widget's hit flag and colour, resolves priority against a background colour, and drives the registered RGB and sync pins. It also issues the once-per-frame `frameTick` that widgets use as their motion `enable`. It sits between the widget instances and the board's VGA connector.

## Interface
Parameters:
- `H_VISIBLE`, 800, visible pixels per line
- `H_FRONT`, 56, horizontal front porch
- `H_SYNC`, 120, hsync pulse width
- `H_BACK`, 64, horizontal back porch (line total 1040)
- `V_VISIBLE`, 600, visible lines
- `V_FRONT`, 37, vertical front porch
- `V_SYNC`, 6, vsync pulse width
- `V_BACK`, 23, vertical back porch (frame total 666)

Ports:
- `clk`  in  1  pixel clock, 50 MHz; all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `X`  out  11  current pixel column counter, 0..1039
- `Y`  out  11  current line counter, 0..665
- `yes0`  in  1  widget 0 hit flag for current `X`/`Y` (combinational from widget)
- `red0`, `green0`, `blue0`  in  4 each  widget 0 colour
- `yes1`  in  1  widget 1 hit flag
- `red1`, `green1`, `blue1`  in  4 each  widget 1 colour
- `bgRed`, `bgGreen`, `bgBlue`  in  4 each  background colour
- `red`, `green`, `blue`  out  4 each  registered pixel colour to DAC
- `hsync`, `vsync`  out  1 each  registered sync, active-high
- `frameTick`  out  1  one-cycle pulse per frame, start of vertical blanking

## Operation
- Counters: `X` increments every clock. At `X`=1039 it wraps to 0 and `Y` increments. At `X`=1039 and `Y`=665 both wrap to 0.
- Counter widths are 11 bits unsigned. Counters never exceed their totals.
- Active region: `X`<800 and `Y`<600.
- Colour select is registered each clock, evaluated in this order:
  - outside the active region: 0/0/0
  - else if `yes0`: widget 0 colour
  - else if `yes1`: widget 1 colour
  - else: background colour
- Widget 0 has priority when both hit.
- `hsync` is registered as 1 when 856 ≤ `X` ≤ 975.
- `vsync` is registered as 1 when 637 ≤ `Y` ≤ 642.
- `frameTick` is registered as 1 when `X`=0 and `Y`=600, otherwise 0. This gives exactly one pulse per frame.
- No FSM beyond the counter pair. Blanking and sync are pure decodes of the counters.

## Timing
- Reset asserted (`reset`=0) forces the following immediately, without waiting for a clock edge:
  - `X`=0, `Y`=0
  - `red`/`green`/`blue`=0
  - `hsync`=0, `vsync`=0, `frameTick`=0
- Counting resumes on the first rising edge after `reset` returns to 1.
- `X`/`Y` are the counter registers. RGB, `hsync`, `vsync` and `frameTick` are one cycle behind the `X`/`Y` that produced them, so colour and sync stay mutually aligned.
- Widget `yes`/colour inputs must settle within one clock of an `X`/`Y` change.
- Reset mid-frame: the frame restarts at `X`=0, `Y`=0. No `frameTick` is produced for the aborted frame.
- Frame period: 1040 × 666 = 692 640 clocks (≈72.2 Hz). Line period: 1040 clocks (≈48.1 kHz).

## Configuration
- `VGA_BORDER_EN` defined:
  - Active pixels with `X`=0, `X`=799, `Y`=0 or `Y`=599 are output as 4'hF/4'hF/4'hF.
  - The border overrides both widgets and the background.
  - Blanking still outputs black.
- `VGA_BORDER_EN` undefined: no border logic. Edge pixels follow normal priority.

## Test plan
- Reset: hold `reset`=0 for 5 clocks -> `X`=0, `Y`=0, all colour outputs 0, `hsync`=`vsync`=`frameTick`=0, including mid-frame assertion at `X`=500, `Y`=300.
- Line timing: release reset, count clocks -> `hsync` rises 857 clocks after release, stays high 120 clocks, and repeats every 1040 clocks. `X` wraps 1039->0 with `Y` 0->1.
- Frame timing: run 2 frames -> `vsync` high for 6×1040 clocks starting at line 637. `frameTick` is high exactly one clock, 692 640 clocks apart.
- Priority: bg=1/2/3, widget0=F/0/0, widget1=0/F/0; drive `yes0`=`yes1`=1 at `X`=100, `Y`=100 -> next-cycle RGB = F/0/0. With `yes0`=0 -> 0/F/0. With both 0 -> 1/2/3.
- Blanking: `yes0`=1 and bg nonzero at `X`=900 or `Y`=620 -> RGB = 0/0/0.
- Border (`VGA_BORDER_EN` defined): at `X`=0, `Y`=50 with `yes0`=1 -> F/F/F. Same stimulus without the macro -> widget 0 colour.
